aes_sel_err_collect: RTL and testbench



---
 rtl/aes_sel_err_collect.sv | 144 ++++++++++++++
 tb/tb_aes_sel_err_collect.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sel_err_collect.sv
// aes_sel_err_collect: collects the err_i outputs of all sparse mux-selector checkers,
// latches a sticky fatal flag, records the first checker that fired, counts error cycles
// and drives a four-phase req/ack handshake towards the alert sender. The handshake
// re-fires continuously while the fatal flag is set.
// Build option: define AES_SEL_ERR_FORCE_EN to add the force_err_i DV hook.
module aes_sel_err_collect #(
    parameter int unsigned NumChk = 8,
    parameter int unsigned CntW   = 8,
    localparam int unsigned SrcW  = (NumChk > 1) ? $clog2(NumChk) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumChk-1:0] err_i,
    input  logic              alert_test_i,
    input  logic              alert_ack_i,
`ifdef AES_SEL_ERR_FORCE_EN
    input  logic              force_err_i,
`endif
    output logic              alert_req_o,
    output logic              fatal_o,
    output logic [NumChk-1:0] err_src_o,
    output logic              first_vld_o,
    output logic [SrcW-1:0]   first_src_o,
    output logic [CntW-1:0]   err_cnt_o
);

    // Sparse encoding, pairwise Hamming distance >= 3 so a single upset cannot
    // turn one legal state into another.
    typedef enum logic [5:0] {
        StIdle    = 6'b111000,
        StReq     = 6'b000111,
        StAckWait = 6'b101101
    } state_e;

    // State kept as plain bits so any corrupted value is representable and caught.
    logic [5:0]        r_state_q;
    logic [5:0]        w_state_d;
    logic              w_state_invalid;
    logic              r_req_q;
    logic              r_fatal_q;
    logic [NumChk-1:0] r_err_src_q;
    logic              r_first_vld_q;
    logic [SrcW-1:0]   r_first_src_q;
    logic [CntW-1:0]   r_cnt_q;

    logic              w_force;
    logic              w_real_err;
    logic              w_any_err;
    logic              w_err_cycle;
    logic              w_cnt_sat;
    logic [SrcW-1:0]   w_lowest;

`ifdef AES_SEL_ERR_FORCE_EN
    assign w_force = force_err_i;
`else
    assign w_force = 1'b0;
`endif

    assign w_real_err  = |err_i;
    assign w_any_err   = w_real_err | w_force;
    // A corrupted FSM state is itself treated as an error cycle.
    assign w_err_cycle = w_any_err | w_state_invalid;
    assign w_cnt_sat   = (r_cnt_q == {CntW{1'b1}});

    // Lowest set index of err_i in the current cycle.
    always_comb begin
        w_lowest = '0;
        for (int i = NumChk - 1; i >= 0; i--) begin
            if (err_i[i]) begin
                w_lowest = SrcW'(i);
            end
        end
    end

    // Alert handshake next-state; any illegal encoding recovers into REQ.
    always_comb begin
        w_state_d       = r_state_q;
        w_state_invalid = 1'b0;
        case (r_state_q)
            StIdle: begin
                if (w_any_err || r_fatal_q || alert_test_i) begin
                    w_state_d = StReq;
                end
            end
            StReq: begin
                if (alert_ack_i) begin
                    w_state_d = StAckWait;
                end
            end
            StAckWait: begin
                if (!alert_ack_i) begin
                    w_state_d = (r_fatal_q || w_any_err) ? StReq : StIdle;
                end
            end
            default: begin
                w_state_d       = StReq;
                w_state_invalid = 1'b1;
            end
        endcase
    end

    // FSM state flops and registered alert request, kept in their own flop group.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q <= StIdle;
            r_req_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_req_q   <= (w_state_d == StReq);
        end
    end

    // Sticky error record: fatal flag, source mask, first source and saturating count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fatal_q     <= 1'b0;
            r_err_src_q   <= '0;
            r_first_vld_q <= 1'b0;
            r_first_src_q <= '0;
            r_cnt_q       <= '0;
        end else begin
            r_err_src_q <= r_err_src_q | err_i;
            if (w_err_cycle) begin
                r_fatal_q <= 1'b1;
            end
            if (w_err_cycle && !w_cnt_sat) begin
                r_cnt_q <= r_cnt_q + CntW'(1);
            end
            // Forced errors and FSM corruption carry no checker index.
            if (w_real_err && !r_first_vld_q) begin
                r_first_vld_q <= 1'b1;
                r_first_src_q <= w_lowest;
            end
        end
    end

    assign alert_req_o = r_req_q;
    assign fatal_o     = r_fatal_q;
    assign err_src_o   = r_err_src_q;
    assign first_vld_o = r_first_vld_q;
    assign first_src_o = r_first_src_q;
    assign err_cnt_o   = r_cnt_q;

endmodule

// File: tb/tb_aes_sel_err_collect.sv
// tb_aes_sel_err_collect: directed and randomized checks of aes_sel_err_collect against a
// behavioural model of the sticky error record plus handshake protocol rules.
module tb_aes_sel_err_collect;

    localparam int unsigned NumChk = 8;
    localparam int unsigned CntW   = 8;
    localparam int unsigned SrcW   = 3;
    localparam int          CntMax = (1 << CntW) - 1;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [NumChk-1:0] err_i;
    logic              alert_test_i;
    logic              alert_ack_i;
    logic              alert_req_o;
    logic              fatal_o;
    logic [NumChk-1:0] err_src_o;
    logic              first_vld_o;
    logic [SrcW-1:0]   first_src_o;
    logic [CntW-1:0]   err_cnt_o;

    always #5 clk_i = ~clk_i;

    aes_sel_err_collect #(
        .NumChk(NumChk),
        .CntW  (CntW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .err_i       (err_i),
        .alert_test_i(alert_test_i),
        .alert_ack_i (alert_ack_i),
`ifdef AES_SEL_ERR_FORCE_EN
        .force_err_i (1'b0),
`endif
        .alert_req_o (alert_req_o),
        .fatal_o     (fatal_o),
        .err_src_o   (err_src_o),
        .first_vld_o (first_vld_o),
        .first_src_o (first_src_o),
        .err_cnt_o   (err_cnt_o)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model of the sticky record.
    logic        m_fatal;
    logic [7:0]  m_src;
    logic        m_vld;
    int          m_first;
    int          m_cnt;

    // Ack responder: ack follows req with a few cycles of delay.
    logic [2:0]  ack_hist;
    bit          resp_en;
    int          rises;
    logic        prev_req;
    logic        prev_ack;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fatal = 1'b0;
        m_src   = '0;
        m_vld   = 1'b0;
        m_first = 0;
        m_cnt   = 0;
    endtask

    task automatic model_cycle(input logic [7:0] e);
        if (e != 8'h00) begin
            m_fatal = 1'b1;
            if (m_cnt < CntMax) m_cnt = m_cnt + 1;
            if (!m_vld) begin
                m_vld = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    if (e[i]) begin
                        m_first = i;
                        break;
                    end
                end
            end
        end
        m_src = m_src | e;
    endtask

    task automatic tick();
        model_cycle(err_i);
        prev_req = alert_req_o;
        prev_ack = alert_ack_i;
        @(posedge clk_i);
        @(negedge clk_i);
        if (!prev_req && alert_req_o) rises++;
        if (resp_en) begin
            ack_hist    = {ack_hist[1:0], alert_req_o};
            alert_ack_i = ack_hist[2];
        end
        alert_test_i = 1'b0;
    endtask

    task automatic check_sticky(input string tag);
        check({tag, "_fatal"}, {31'd0, fatal_o}, {31'd0, m_fatal});
        check({tag, "_src"}, {24'd0, err_src_o}, {24'd0, m_src});
        check({tag, "_vld"}, {31'd0, first_vld_o}, {31'd0, m_vld});
        check({tag, "_first"}, {29'd0, first_src_o}, 32'(m_first));
        check({tag, "_cnt"}, {24'd0, err_cnt_o}, 32'(m_cnt));
    endtask

    // Four-phase rules: req may only fall after ack was seen high, only rise with ack low.
    task automatic check_proto(input string tag);
        if (prev_req && !alert_req_o) check({tag, "_fall_ack"}, {31'd0, prev_ack}, 32'd1);
        if (!prev_req && alert_req_o) check({tag, "_rise_ack"}, {31'd0, prev_ack}, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst_ni = 1'b0;
        #1;
        check({tag, "_rst_req"}, {31'd0, alert_req_o}, 32'd0);
        check({tag, "_rst_fatal"}, {31'd0, fatal_o}, 32'd0);
        check({tag, "_rst_src"}, {24'd0, err_src_o}, 32'd0);
        check({tag, "_rst_vld"}, {31'd0, first_vld_o}, 32'd0);
        check({tag, "_rst_first"}, {29'd0, first_src_o}, 32'd0);
        check({tag, "_rst_cnt"}, {24'd0, err_cnt_o}, 32'd0);
        model_reset();
        err_i        = '0;
        alert_test_i = 1'b0;
        alert_ack_i  = 1'b0;
        ack_hist     = '0;
        resp_en      = 1'b1;
        rises        = 0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_ni       = 1'b1;
        err_i        = '0;
        alert_test_i = 1'b0;
        alert_ack_i  = 1'b0;
        #2;

        // Idle: nothing fires.
        do_reset("idle");
        for (int c = 0; c < 20; c++) begin
            tick();
            check("idle_req", {31'd0, alert_req_o}, 32'd0);
            check_sticky("idle");
        end

        // Single-cycle error 8'h24 at cycle 5, then continuous re-firing.
        do_reset("e24");
        repeat (4) tick();
        err_i = 8'h24;
        tick();
        err_i = '0;
        check("e24_fatal", {31'd0, fatal_o}, 32'd1);
        check("e24_req", {31'd0, alert_req_o}, 32'd1);
        check("e24_first", {29'd0, first_src_o}, 32'd2);
        check("e24_vld", {31'd0, first_vld_o}, 32'd1);
        check("e24_src", {24'd0, err_src_o}, 32'h24);
        check("e24_cnt", {24'd0, err_cnt_o}, 32'd1);
        rises = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            check_sticky("refire");
            check_proto("refire");
        end
        check("refire_count", 32'(rises >= 8), 32'd1);

        // Test alert in IDLE: exactly one handshake, no fatal.
        do_reset("tst");
        alert_test_i = 1'b1;
        rises = 0;
        tick();
        check("tst_req", {31'd0, alert_req_o}, 32'd1);
        for (int c = 0; c < 25; c++) begin
            tick();
            check_sticky("tst");
            check_proto("tst");
        end
        check("tst_rises", 32'(rises), 32'd1);
        check("tst_req_end", {31'd0, alert_req_o}, 32'd0);
        check("tst_fatal", {31'd0, fatal_o}, 32'd0);

        // Ack high in IDLE is ignored; ack still high on entering REQ advances next edge.
        do_reset("ack");
        resp_en     = 1'b0;
        alert_ack_i = 1'b1;
        repeat (5) begin
            tick();
            check("ack_idle_req", {31'd0, alert_req_o}, 32'd0);
        end
        err_i = 8'h80;
        tick();
        err_i = '0;
        check("ack_enter_req", {31'd0, alert_req_o}, 32'd1);
        check("ack_first", {29'd0, first_src_o}, 32'd7);
        tick();
        check("ack_early_adv", {31'd0, alert_req_o}, 32'd0);
        alert_ack_i = 1'b0;
        tick();
        check("ack_refire", {31'd0, alert_req_o}, 32'd1);
        check_sticky("ack");

        // Simultaneous test pulse and error in IDLE.
        do_reset("sim");
        alert_test_i = 1'b1;
        err_i        = 8'h10;
        tick();
        err_i = '0;
        check("sim_fatal", {31'd0, fatal_o}, 32'd1);
        check("sim_req", {31'd0, alert_req_o}, 32'd1);
        check("sim_first", {29'd0, first_src_o}, 32'd4);
        rises = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            check_proto("sim");
        end
        check("sim_rises", 32'(rises >= 3), 32'd1);

        // Saturation of the error-cycle counter.
        do_reset("sat");
        err_i = 8'h01;
        for (int c = 0; c < 300; c++) begin
            tick();
            check_sticky("sat");
        end
        err_i = '0;
        check("sat_cnt", {24'd0, err_cnt_o}, CntMax);

        // Randomized rounds.
        for (int r = 0; r < 3; r++) begin
            do_reset("rnd");
            for (int c = 0; c < 80; c++) begin
                err_i        = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
                alert_test_i = ($urandom_range(0, 9) == 0);
                tick();
                check_sticky("rnd");
                check_proto("rnd");
            end
        end

        // Corrupted FSM state, then reset while in REQ.
        do_reset("inv");
        repeat (3) tick();
        force dut.r_state_q = 6'b010101;
        @(posedge clk_i);
        #1;
        release dut.r_state_q;
        @(negedge clk_i);
        check("inv_req", {31'd0, alert_req_o}, 32'd1);
        check("inv_fatal", {31'd0, fatal_o}, 32'd1);
        check("inv_cnt", {24'd0, err_cnt_o}, 32'd1);
        check("inv_vld", {31'd0, first_vld_o}, 32'd0);
        check("inv_src", {24'd0, err_src_o}, 32'd0);
        do_reset("midreq");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
